instr_encoder: RTL and testbench

Packs decoded RV32I instruction fields (opcode, registers, funct3/funct7, immediate) into 32-bit instruction words and streams them into instruction memory through a valid/ready handshake. Immediate ranges and alignment are checked before any write. The block is the inverse of the core's instruction decode stage. It serves as the boot/program loader and testbench stimulus source that fills instruction memory before the core runs.

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and instruction-memory write channel of instr_encoder.
// The encoder sits on the slave modport; the bundle source / memory model uses master.
package instr_encoder_pkg;
  typedef logic [6:0]         opcode_t;
  typedef logic signed [31:0] imm_t;
endpackage

interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  opcode_t     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  imm_t        imm;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words and streams them to memory; one-cycle latency,
// single-entry output register, input stalls while a word is pending and memory is not ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  instr_encoder_if.slave  io_bus,
  output logic [CW-1:0]   o_word_count,
  output logic            o_full,
  output logic            o_err,
  output logic [1:0]      o_err_code
);

  localparam opcode_t OP_R     = 7'b0110011;
  localparam opcode_t OP_IL    = 7'b0010011;
  localparam opcode_t OP_LD    = 7'b0000011;
  localparam opcode_t OP_JALR  = 7'b1100111;
  localparam opcode_t OP_FENCE = 7'b0001111;
  localparam opcode_t OP_S     = 7'b0100011;
  localparam opcode_t OP_B     = 7'b1100011;
  localparam opcode_t OP_LUI   = 7'b0110111;
  localparam opcode_t OP_AUIPC = 7'b0010111;
  localparam opcode_t OP_JAL   = 7'b1101111;

  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [CW-1:0] r_word_count;
  logic [CW-1:0] r_accept_cnt;
  logic          r_full;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic [31:0]   w_imm;
  logic [31:0]   w_enc;
  logic          w_known;
  logic          w_bad_range;
  logic          w_bad_align;
  logic [1:0]    w_code;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_commit;

  assign w_imm = io_bus.imm;

  always_comb begin
    w_enc       = '0;
    w_known     = 1'b1;
    w_bad_range = 1'b0;
    w_bad_align = 1'b0;
    case (io_bus.opcode)
      OP_R: w_enc = {io_bus.funct7, io_bus.rs2, io_bus.rs1, io_bus.funct3, io_bus.rd, io_bus.opcode};
      OP_IL, OP_LD, OP_JALR, OP_FENCE: begin
        // Shift-immediate forms carry funct7 in the upper immediate bits.
        if (io_bus.opcode == OP_IL && (io_bus.funct3 == 3'b001 || io_bus.funct3 == 3'b101)) begin
          w_enc       = {io_bus.funct7, w_imm[4:0], io_bus.rs1, io_bus.funct3, io_bus.rd, io_bus.opcode};
          w_bad_range = |w_imm[31:5];
        end else begin
          w_enc       = {w_imm[11:0], io_bus.rs1, io_bus.funct3, io_bus.rd, io_bus.opcode};
          w_bad_range = !(&w_imm[31:11] || ~|w_imm[31:11]);
        end
      end
      OP_S: begin
        w_enc       = {w_imm[11:5], io_bus.rs2, io_bus.rs1, io_bus.funct3, w_imm[4:0], io_bus.opcode};
        w_bad_range = !(&w_imm[31:11] || ~|w_imm[31:11]);
      end
      OP_B: begin
        w_enc       = {w_imm[12], w_imm[10:5], io_bus.rs2, io_bus.rs1, io_bus.funct3,
                       w_imm[4:1], w_imm[11], io_bus.opcode};
        w_bad_range = !(&w_imm[31:12] || ~|w_imm[31:12]);
        w_bad_align = w_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        w_enc       = {w_imm[31:12], io_bus.rd, io_bus.opcode};
        w_bad_range = |w_imm[11:0];
      end
      OP_JAL: begin
        w_enc       = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], io_bus.rd, io_bus.opcode};
        w_bad_range = !(&w_imm[31:20] || ~|w_imm[31:20]);
        w_bad_align = w_imm[0];
      end
      default: w_known = 1'b0;
    endcase
  end

  assign w_code = !w_known   ? 2'b01 :
                  w_bad_align ? 2'b11 :
                  w_bad_range ? 2'b10 : 2'b00;

  assign w_in_ready = !i_reset && !r_full && (!r_mem_we || io_bus.mem_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_commit   = r_mem_we && io_bus.mem_ready && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
      r_accept_cnt <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      if (w_commit) begin
        r_mem_addr   <= r_mem_addr + 32'd4;
        r_word_count <= r_word_count + CW'(1);
      end
      if (w_accept && w_code == 2'b00) begin
        r_mem_we     <= 1'b1;
        r_mem_wdata  <= w_enc;
        r_accept_cnt <= r_accept_cnt + CW'(1);
        if (r_accept_cnt == CW'(DEPTH - 1)) r_full <= 1'b1;
      end else if (w_commit) begin
        r_mem_we <= 1'b0;
      end
      // Illegal bundles are swallowed; only the first error code is kept.
      if (w_accept && w_code != 2'b00) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_code;
      end
    end
  end

  // Gating mem_we with reset keeps a pending word from being written during reset.
  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.mem_we    = r_mem_we && !i_reset;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign o_word_count     = r_word_count;
  assign o_full           = r_full;
  assign o_err            = r_err;
  assign o_err_code       = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, stall, randomized scoreboard and DEPTH=4 fill/reset.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] BASE4 = 32'h8000_0000;

  localparam opcode_t OPS [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111,
                                   7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b1111111};
  localparam imm_t BOUNDS [15] = '{32'sd2047, 32'sd2048, -32'sd2048, -32'sd2049, 32'sd4094,
                                   32'sd4096, -32'sd4096, -32'sd4098, 32'sd1048574, 32'sd1048576,
                                   -32'sd1048576, 32'sd31, 32'sd32, 32'sd4095, 32'sd3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] wc;
  logic       full, err;
  logic [1:0] ec;
  logic [2:0] wc4;
  logic       full4, err4;
  logic [1:0] ec4;
  int         n_cmp = 0;
  int         n_bad = 0;

  instr_encoder_if bus ();
  instr_encoder_if bus4 ();

  instr_encoder #(.BASE_ADDR(BASE)) u_dut (
    .i_clk(clk), .i_reset(reset), .io_bus(bus),
    .o_word_count(wc), .o_full(full), .o_err(err), .o_err_code(ec)
  );

  instr_encoder #(.BASE_ADDR(BASE4), .DEPTH(4)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .io_bus(bus4),
    .o_word_count(wc4), .o_full(full4), .o_err(err4), .o_err_code(ec4)
  );

  always #5 clk = ~clk;

  typedef struct {
    opcode_t    op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    imm_t       imm;
    bit         legal;
    logic [31:0] word;
    logic [1:0] ecode;
  } dvec_t;

  // Reference: legality from numeric ranges of the immediate value.
  function automatic logic [1:0] model_code(opcode_t op, logic [2:0] f3, imm_t imm);
    int v;
    v = imm;
    case (op)
      7'b0110011: return 2'd0;
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) return (v >= 0 && v <= 31) ? 2'd0 : 2'd2;
        return (v >= -2048 && v <= 2047) ? 2'd0 : 2'd2;
      end
      7'b0000011, 7'b1100111, 7'b0001111, 7'b0100011:
        return (v >= -2048 && v <= 2047) ? 2'd0 : 2'd2;
      7'b1100011: begin
        if (v % 2 != 0) return 2'd3;
        return (v >= -4096 && v <= 4095) ? 2'd0 : 2'd2;
      end
      7'b1101111: begin
        if (v % 2 != 0) return 2'd3;
        return (v >= -1048576 && v <= 1048575) ? 2'd0 : 2'd2;
      end
      7'b0110111, 7'b0010111: return (v % 4096 == 0) ? 2'd0 : 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [31:0] fld(logic [31:0] u, int hi, int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_enc(opcode_t op, logic [2:0] f3, logic [6:0] f7,
                                            logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, imm_t imm);
    logic [31:0] u, base;
    u    = imm;
    base = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
    case (op)
      7'b0110011: return base + (32'(rd) << 7) + (32'(rs2) << 20) + (32'(f7) << 25);
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5))
          return base + (32'(rd) << 7) + (fld(u, 4, 0) << 20) + (32'(f7) << 25);
        return base + (32'(rd) << 7) + (fld(u, 11, 0) << 20);
      end
      7'b0100011: return base + (fld(u, 4, 0) << 7) + (32'(rs2) << 20) + (fld(u, 11, 5) << 25);
      7'b1100011: return base + (fld(u, 11, 11) << 7) + (fld(u, 4, 1) << 8) + (32'(rs2) << 20)
                         + (fld(u, 10, 5) << 25) + (fld(u, 12, 12) << 31);
      7'b0110111, 7'b0010111: return 32'(op) + (32'(rd) << 7) + (fld(u, 31, 12) << 12);
      7'b1101111: return 32'(op) + (32'(rd) << 7) + (fld(u, 19, 12) << 12) + (fld(u, 11, 11) << 20)
                         + (fld(u, 10, 1) << 21) + (fld(u, 20, 20) << 31);
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus4.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input opcode_t op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input imm_t imm, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== BASE) begin n_bad++; $display("FAIL rst_mem_addr: got %h expected %h", bus.mem_addr, BASE); end
    n_cmp++; if (bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
    n_cmp++; if (wc !== 9'd0) begin n_bad++; $display("FAIL rst_word_count: got %0d expected 0", wc); end
    n_cmp++; if ({full, err, ec} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b expected 0000", {full, err, ec}); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    dvec_t dv [7];
    bit    ok;
    int    k;
    dv[0] = '{7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'sd0,        1'b1, 32'h002081B3, 2'd0};
    dv[1] = '{7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1,       1'b1, 32'hFFF00093, 2'd0};
    dv[2] = '{7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd2048,     1'b0, 32'h0,        2'd2};
    dv[3] = '{7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4,       1'b1, 32'hFE208EE3, 2'd2};
    dv[4] = '{7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'sd3,        1'b0, 32'h0,        2'd2};
    dv[5] = '{7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd2048,     1'b1, 32'h001000EF, 2'd2};
    dv[6] = '{7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,  1'b1, 32'h123452B7, 2'd2};
    do_reset();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = 1'b0;
      send(dv[i].op, dv[i].f3, dv[i].f7, dv[i].rd, dv[i].rs1, dv[i].rs2, dv[i].imm, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dir_accept[%0d]: got %b expected 1", i, ok); end
      if (dv[i].legal) begin
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL dir_mem_we[%0d]: got %b expected 1", i, bus.mem_we); end
        n_cmp++; if (bus.mem_wdata !== dv[i].word) begin n_bad++; $display("FAIL dir_wdata[%0d]: got %h expected %h", i, bus.mem_wdata, dv[i].word); end
        n_cmp++; if (bus.mem_addr !== BASE + 32'(4 * k)) begin n_bad++; $display("FAIL dir_addr[%0d]: got %h expected %h", i, bus.mem_addr, BASE + 32'(4 * k)); end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        k++;
      end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL dir_idle_we[%0d]: got %b expected 0", i, bus.mem_we); end
      n_cmp++; if (wc !== 9'(k)) begin n_bad++; $display("FAIL dir_word_count[%0d]: got %0d expected %0d", i, wc, k); end
      n_cmp++; if (err !== (dv[i].ecode != 2'd0) || ec !== dv[i].ecode) begin
        n_bad++; $display("FAIL dir_err[%0d]: got err=%b code=%b expected code=%b", i, err, ec, dv[i].ecode);
      end
    end
    do_reset();
    send(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'sd0, ok);
    n_cmp++; if (err !== 1'b1 || ec !== 2'b01) begin n_bad++; $display("FAIL dir_unknown_op: got err=%b code=%b expected err=1 code=01", err, ec); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL dir_unknown_we: got %b expected 0", bus.mem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    do_reset();
    for (int k = 0; k < 3; k++) exp_w[k] = model_enc(7'b0010011, 3'd0, 7'd0, 5'(k + 1), 5'(k), 5'd0, imm_t'(k * 100 - 50));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.opcode = 7'b0010011; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.rs2 = 5'd0;
    bus.rd = 5'd1; bus.rs1 = 5'd0; bus.imm = -32'sd50;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.rd = 5'd2; bus.rs1 = 5'd1; bus.imm = 32'sd50;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== BASE || bus.mem_wdata !== exp_w[0]) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, BASE, exp_w[0]);
      end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, bus.in_ready); end
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== BASE + 32'(4 * k) || bus.mem_wdata !== exp_w[k]) begin
        n_bad++; $display("FAIL b2b_word[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, BASE + 32'(4 * k), exp_w[k]);
      end
      if (k == 1) begin bus.rd = 5'd3; bus.rs1 = 5'd2; bus.imm = 32'sd150; end
      if (k == 2) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (wc !== 9'd3 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got count=%0d we=%b expected count=3 we=0", wc, bus.mem_we); end
  endtask

  task automatic rand_fields();
    bus.opcode = OPS[$urandom_range(0, 10)];
    bus.funct3 = 3'($urandom);
    bus.funct7 = 7'($urandom);
    bus.rd     = 5'($urandom);
    bus.rs1    = 5'($urandom);
    bus.rs2    = 5'($urandom);
    case ($urandom_range(0, 4))
      0:       bus.imm = 32'($urandom_range(0, 63)) - 32'd32;
      1:       bus.imm = BOUNDS[$urandom_range(0, 14)];
      2:       bus.imm = $urandom;
      3:       bus.imm = $urandom & 32'hFFFF_F000;
      default: bus.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
    endcase
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    int          n_legal = 0;
    int          n_commit = 0;
    logic [1:0]  mcode = 2'd0;
    logic [1:0]  c;
    bit          fired = 1'b0;
    bit          exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (fired || !bus.in_valid) begin
        bus.in_valid = 1'b0;
        if (cyc < 285 && $urandom_range(0, 3) != 0) begin rand_fields(); bus.in_valid = 1'b1; end
      end
      fired = 1'b0;
      bus.mem_ready = (cyc >= 285) || ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (n_legal < 256) && (q.size() == 0 || bus.mem_ready);
      n_cmp++; if (bus.mem_we !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_mem_we@%0d: got %b expected %b", cyc, bus.mem_we, q.size() != 0); end
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, bus.in_ready, exp_rdy); end
      n_cmp++; if (err !== (mcode != 2'd0) || ec !== mcode) begin n_bad++; $display("FAIL rnd_err@%0d: got err=%b code=%b expected code=%b", cyc, err, ec, mcode); end
      n_cmp++; if (wc !== 9'(n_commit)) begin n_bad++; $display("FAIL rnd_word_count@%0d: got %0d expected %0d", cyc, wc, n_commit); end
      if (q.size() != 0 && bus.mem_ready) begin
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== q[0]) begin
          n_bad++; $display("FAIL rnd_commit@%0d: got addr=%h data=%h expected addr=%h data=%h", cyc, bus.mem_addr, bus.mem_wdata, q[0][63:32], q[0][31:0]);
        end
        void'(q.pop_front());
        n_commit++;
      end
      if (bus.in_valid && bus.in_ready) begin
        fired = 1'b1;
        c = model_code(bus.opcode, bus.funct3, bus.imm);
        if (c == 2'd0) begin
          q.push_back({BASE + 32'(4 * n_legal), model_enc(bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm)});
          n_legal++;
        end else if (mcode == 2'd0) begin
          mcode = c;
        end
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d words outstanding expected 0", q.size()); end
  endtask

  task automatic test_full();
    logic [31:0] w3;
    w3 = model_enc(7'b0010011, 3'd0, 7'd0, 5'd4, 5'd3, 5'd0, 32'sd9);
    do_reset();
    bus4.mem_ready = 1'b1;
    bus4.opcode = 7'b0010011; bus4.funct3 = 3'd0; bus4.funct7 = 7'd0; bus4.rs2 = 5'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus4.rd = 5'(k + 1); bus4.rs1 = 5'(k); bus4.imm = imm_t'(k * 3);
      bus4.in_valid = 1'b1;
      #1;
      n_cmp++; if (bus4.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready[%0d]: got %b expected 1", k, bus4.in_ready); end
    end
    @(negedge clk);
    bus4.mem_ready = 1'b0;
    bus4.rd = 5'd9; bus4.imm = 32'sd7;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (full4 !== 1'b1 || bus4.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_flag[%0d]: got full=%b in_ready=%b expected full=1 in_ready=0", c, full4, bus4.in_ready); end
      n_cmp++; if (bus4.mem_we !== 1'b1 || bus4.mem_wdata !== w3 || bus4.mem_addr !== BASE4 + 32'd12 || wc4 !== 3'd3) begin
        n_bad++; $display("FAIL full_pending[%0d]: got we=%b data=%h addr=%h count=%0d expected we=1 data=%h addr=%h count=3", c, bus4.mem_we, bus4.mem_wdata, bus4.mem_addr, wc4, w3, BASE4 + 32'd12);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    bus4.mem_ready = 1'b1;
    #1;
    n_cmp++; if (bus4.mem_we !== 1'b0 || bus4.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_reset_nowrite: got we=%b in_ready=%b expected 0 0", bus4.mem_we, bus4.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    bus4.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus4.mem_we !== 1'b0 || bus4.mem_addr !== BASE4 || bus4.mem_wdata !== 32'd0) begin
      n_bad++; $display("FAIL full_reset_out: got we=%b addr=%h data=%h expected we=0 addr=%h data=0", bus4.mem_we, bus4.mem_addr, bus4.mem_wdata, BASE4);
    end
    n_cmp++; if (wc4 !== 3'd0 || {full4, err4, ec4} !== 4'b0000) begin n_bad++; $display("FAIL full_reset_state: got count=%0d flags=%b expected 0 0000", wc4, {full4, err4, ec4}); end
    n_cmp++; if (bus4.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_reset_ready: got %b expected 1", bus4.in_ready); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;  bus.mem_ready = 1'b1;  bus.opcode = '0;  bus.funct3 = '0;
    bus.funct7 = '0;  bus.rd = '0;  bus.rs1 = '0;  bus.rs2 = '0;  bus.imm = '0;
    bus4.in_valid = 1'b0; bus4.mem_ready = 1'b1; bus4.opcode = '0; bus4.funct3 = '0;
    bus4.funct7 = '0; bus4.rd = '0; bus4.rs1 = '0; bus4.rs2 = '0; bus4.imm = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
